// File: rtl/alu_core_if.sv
// ---------------------------------------------------------------------------
// alu_core_if : operand / result bundle between issue logic and the ALU.
// The master drives operands and opcode; the slave (ALU) returns the
// registered result and NZCV flags.
// ---------------------------------------------------------------------------
interface alu_core_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output op1,
    output op2,
    output alu_control,
    input  result,
    input  flags
  );

  modport slave (
    input  op1,
    input  op2,
    input  alu_control,
    output result,
    output flags
  );
endinterface : alu_core_if

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core : single-cycle integer ALU for the execute stage.
// Eight operations (add, sub, and, or, xor, sll, srl, sra) are evaluated
// combinationally from the current operands; the chosen result and its
// {N, Z, C, V} status are captured on every rising clock edge.
// ---------------------------------------------------------------------------
module alu_core #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_core_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } alu_op_e;

  // WIDTH expressed at WIDTH+1 bits so it can be compared with a
  // zero-extended shift amount without overflowing for small WIDTH.
  localparam logic [WIDTH:0] WIDTH_EXT = (WIDTH + 1)'(WIDTH);

  alu_op_e          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // Adder shared by ADD and SUB: SUB feeds ~B with a carry-in of 1.
  logic             is_sub;
  logic [WIDTH-1:0] b_add;
  logic [WIDTH:0]   sum_ext;

  // Shifter helpers.
  logic             shift_oob;
  logic [WIDTH-1:0] sll_res;
  logic [WIDTH-1:0] srl_res;
  logic [WIDTH-1:0] sra_res;

  // Registered outputs and their next values.
  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flags_d,  flags_q;
  logic             carry_d;
  logic             ovf_d;

  assign op = alu_op_e'(bus.alu_control);
  assign a  = bus.op1;
  assign b  = bus.op2;

  // Shared add/subtract datapath with a WIDTH+1-bit sum to expose the carry.
  always_comb begin
    is_sub  = (op == OP_SUB);
    b_add   = is_sub ? ~b : b;
    sum_ext = {1'b0, a} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
  end

  // Shifter: amounts of WIDTH or more saturate to 0 or to sign copies of A.
  always_comb begin
    shift_oob = ({1'b0, b} >= WIDTH_EXT);
    if (shift_oob) begin
      sll_res = '0;
      srl_res = '0;
      sra_res = {WIDTH{a[WIDTH-1]}};
    end else begin
      sll_res = a << b;
      srl_res = a >> b;
      sra_res = $signed(a) >>> b;
    end
  end

  // Result select plus carry / overflow for the arithmetic ops.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value held and no latch is inferred.
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    unique case (op)
      OP_ADD: begin
        result_d = sum_ext[WIDTH-1:0];
        carry_d  = sum_ext[WIDTH];
        ovf_d    = (a[WIDTH-1] == b[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1 is the inverted borrow: 1 when A >= B.
        result_d = sum_ext[WIDTH-1:0];
        carry_d  = sum_ext[WIDTH];
        ovf_d    = (a[WIDTH-1] != b[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result_d = a & b;
      OP_OR:  result_d = a | b;
      OP_XOR: result_d = a ^ b;
      OP_SLL: result_d = sll_res;
      OP_SRL: result_d = srl_res;
      OP_SRA: result_d = sra_res;
      default: result_d = '0;
    endcase
  end

  // NZCV status derived from the same-cycle result.
  always_comb begin
    flags_d = {result_d[WIDTH-1], (result_d == '0), carry_d, ovf_d};
  end

  // Output registers with synchronous reset; reset overrides any operation.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    if (reset) begin
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule : alu_core

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core : self-checking bench for alu_core at WIDTH=4.
// Directed vectors plus randomized operations compared against an
// integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_core;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  alu_core_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Hard stop in case anything ever stalls the clocked sequence.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model using plain integer arithmetic on signed/unsigned views.
  function automatic void model(input int a, input int b, input int op,
                                output int res, output logic [3:0] fl);
    int sa, sb, full, s;
    logic c, v;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    c = 1'b0;
    v = 1'b0;
    res = 0;
    case (op)
      0: begin
        full = a + b;
        res  = full % M;
        c    = (full >= M);
        s    = sa + sb;
        v    = (s < -(M / 2)) || (s >= M / 2);
      end
      1: begin
        full = a - b;
        res  = (full + M) % M;
        c    = (a >= b);
        s    = sa - sb;
        v    = (s < -(M / 2)) || (s >= M / 2);
      end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: res = (b >= W) ? 0 : (a * (1 << b)) % M;
      6: res = (b >= W) ? 0 : a / (1 << b);
      default: begin
        if (b >= W) res = (sa < 0) ? M - 1 : 0;
        else begin
          s   = sa >>> b;
          res = (s + M) % M;
        end
      end
    endcase
    fl = {(res >= M / 2), (res == 0), c, v};
  endfunction

  // Drive one operation, clock it, and settle just after the edge.
  task automatic apply(input int a, input int b, input int op);
    logic [31:0] av, bv, ov;
    av = a; bv = b; ov = op;
    bus.op1         = av[W-1:0];
    bus.op2         = bv[W-1:0];
    bus.alu_control = ov[2:0];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      reset = 1'b1;
      apply(7, 1, 0);
      n_cmp++;
      if (bus.result !== 4'd0 || bus.flags !== 4'b0000) begin
        n_mis++;
        $display("FAIL reset_hold[%0d]: got result=%b flags=%b, want 0000/0000",
                 i, bus.result, bus.flags);
      end
    end
    reset = 1'b0;
  endtask

  typedef struct {
    int a; int b; int op; int res; logic [3:0] fl; string name;
  } vec_t;

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{7, 1, 0, 4'b1000, 4'b1001, "add_ovf"});
    v.push_back('{7, 1, 1, 4'b0110, 4'b0010, "sub_7_1"});
    v.push_back('{5, 5, 1, 4'b0000, 4'b0110, "sub_equal"});
    v.push_back('{5, 5, 2, 4'b0101, 4'b0000, "and_equal"});
    v.push_back('{5, 5, 3, 4'b0101, 4'b0000, "or_equal"});
    v.push_back('{5, 5, 4, 4'b0000, 4'b0100, "xor_equal"});
    v.push_back('{13, 7, 0, 4'b0100, 4'b0010, "add_carry"});
    // -3 - 7 = -10 does not fit in 4 signed bits, so V is set.
    v.push_back('{13, 7, 1, 4'b0110, 4'b0011, "sub_13_7"});
    // Shift amount 7 is at least WIDTH: logical right gives zero.
    v.push_back('{13, 7, 6, 4'b0000, 4'b0100, "srl_oob"});
    v.push_back('{13, 7, 7, 4'b1111, 4'b1000, "sra_oob"});
    v.push_back('{1, 15, 1, 4'b0010, 4'b0000, "sub_borrow"});
    v.push_back('{1, 15, 0, 4'b0000, 4'b0110, "add_wrap"});
    v.push_back('{1, 15, 5, 4'b0000, 4'b0100, "sll_oob"});
    v.push_back('{15, 1, 5, 4'b1110, 4'b1000, "sll_1"});
    v.push_back('{15, 1, 6, 4'b0111, 4'b0000, "srl_1"});
    v.push_back('{15, 1, 7, 4'b1111, 4'b1000, "sra_1"});
    v.push_back('{8, 3, 7, 4'b1111, 4'b1000, "sra_3"});
    v.push_back('{8, 1, 1, 4'b0111, 4'b0011, "sub_ovf"});
    foreach (v[i]) begin
      apply(v[i].a, v[i].b, v[i].op);
      n_cmp++;
      if (bus.result !== v[i].res[W-1:0] || bus.flags !== v[i].fl) begin
        n_mis++;
        $display("FAIL %s: got result=%b flags=%b, want result=%b flags=%b",
                 v[i].name, bus.result, bus.flags, v[i].res[W-1:0], v[i].fl);
      end
    end
  endtask

  task automatic test_reset_midstream();
    reset = 1'b0;
    apply(7, 1, 0);
    n_cmp++;
    if (bus.result !== 4'b1000 || bus.flags !== 4'b1001) begin
      n_mis++;
      $display("FAIL pre_reset: got %b/%b, want 1000/1001", bus.result, bus.flags);
    end
    reset = 1'b1;
    apply(7, 1, 0);
    n_cmp++;
    if (bus.result !== 4'b0000 || bus.flags !== 4'b0000) begin
      n_mis++;
      $display("FAIL mid_reset: got %b/%b, want 0000/0000", bus.result, bus.flags);
    end
    reset = 1'b0;
    apply(7, 1, 0);
    n_cmp++;
    if (bus.result !== 4'b1000 || bus.flags !== 4'b1001) begin
      n_mis++;
      $display("FAIL post_reset: got %b/%b, want 1000/1001", bus.result, bus.flags);
    end
  endtask

  // Random operations every cycle with occasional reset pulses.
  task automatic test_back_to_back();
    int a, b, op, res;
    logic [3:0] fl;
    logic rst;
    for (int i = 0; i < 400; i++) begin
      a   = $urandom_range(0, M - 1);
      b   = $urandom_range(0, M - 1);
      op  = $urandom_range(0, 7);
      rst = ($urandom_range(0, 19) == 0);
      reset = rst;
      apply(a, b, op);
      if (rst) begin
        res = 0;
        fl  = 4'b0000;
      end else begin
        model(a, b, op, res, fl);
      end
      n_cmp++;
      if (bus.result !== res[W-1:0] || bus.flags !== fl) begin
        n_mis++;
        $display("FAIL rand[%0d] a=%0d b=%0d op=%0d rst=%0b: got %b/%b, want %b/%b",
                 i, a, b, op, rst, bus.result, bus.flags, res[W-1:0], fl);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.op1         = '0;
    bus.op2         = '0;
    bus.alu_control = '0;
    test_reset();
    test_directed();
    test_reset_midstream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_alu_core
